// File: rtl/set_stage.sv
// set_stage: registered compare-and-set stage of the ALU.
// Two-deep valid/ready pipeline: S1 holds the operands and opcode, S2 holds
// the set result and the condition flags. Results emerge two cycles after
// the request is presented when the pipeline is not stalled.
// Optional feature macro: CMP_UNSIGNED_EN enables the LTU/GEU opcodes.
// Without it, opcodes 110/111 complete with result 0 and flags 4'b1000.
module set_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_flags
);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LE  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    localparam logic [3:0] FLAGS_ILLEGAL = 4'b1000;

    // Stage 1: captured request
    logic         s1_valid_r;
    logic [N-1:0] s1_a_r;
    logic [N-1:0] s1_b_r;
    logic [2:0]   s1_op_r;

    // Stage 2: compare result
    logic         s2_valid_r;
    logic         s2_cond_r;
    logic [3:0]   s2_flags_r;

    // Handshake and compare nets
    logic         s2_free_s;
    logic         s1_free_s;
    logic         in_accept_s;
    logic         eq_s;
    logic         mag_lt_s;
    logic         mag_gt_s;
    logic         msb_diff_s;
    logic         slt_s;
    logic         sgt_s;
    logic         cond_s;
    logic [3:0]   flags_s;

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_free_s   = ~s2_valid_r | out_ready;
    assign s1_free_s   = ~s1_valid_r | s2_free_s;
    assign in_ready    = s1_free_s;
    assign in_accept_s = in_valid & s1_free_s;

    assign out_valid  = s2_valid_r;
    assign out_result = {{(N-1){1'b0}}, s2_cond_r};
    assign out_flags  = s2_flags_r;

    // Equality and magnitude compare of the S1 operands, signed via MSB check.
    always_comb begin
        eq_s       = (s1_a_r == s1_b_r);
        mag_lt_s   = (s1_a_r < s1_b_r);
        mag_gt_s   = (s1_a_r > s1_b_r);
        msb_diff_s = s1_a_r[N-1] ^ s1_b_r[N-1];
        if (msb_diff_s) begin
            // The operand with its sign bit set is the smaller one.
            slt_s = s1_a_r[N-1];
            sgt_s = s1_b_r[N-1];
        end else begin
            slt_s = mag_lt_s;
            sgt_s = mag_gt_s;
        end
    end

    // Map the opcode onto the set condition and the reported flags.
    always_comb begin
        cond_s  = 1'b0;
        flags_s = {1'b0, sgt_s, slt_s, eq_s};
        case (s1_op_r)
            OP_EQ:   cond_s = eq_s;
            OP_NE:   cond_s = ~eq_s;
            OP_LT:   cond_s = slt_s;
            OP_GE:   cond_s = ~slt_s;
            OP_LE:   cond_s = slt_s | eq_s;
            OP_GT:   cond_s = sgt_s;
`ifdef CMP_UNSIGNED_EN
            OP_LTU: begin
                cond_s  = mag_lt_s;
                flags_s = {1'b0, mag_gt_s, mag_lt_s, eq_s};
            end
            OP_GEU: begin
                cond_s  = ~mag_lt_s;
                flags_s = {1'b0, mag_gt_s, mag_lt_s, eq_s};
            end
`else
            OP_LTU: begin
                cond_s  = 1'b0;
                flags_s = FLAGS_ILLEGAL;
            end
            OP_GEU: begin
                cond_s  = 1'b0;
                flags_s = FLAGS_ILLEGAL;
            end
`endif
            default: begin
                cond_s  = 1'b0;
                flags_s = FLAGS_ILLEGAL;
            end
        endcase
    end

    // S1 valid bit follows the upstream request whenever the stage can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (s1_free_s) begin
            s1_valid_r <= in_valid;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S1 operand/opcode capture on input accept; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_r  <= '0;
            s1_b_r  <= '0;
            s1_op_r <= 3'b000;
        end else if (in_accept_s) begin
            s1_a_r  <= in_a;
            s1_b_r  <= in_b;
            s1_op_r <= in_op;
        end else begin
            s1_a_r  <= s1_a_r;
            s1_b_r  <= s1_b_r;
            s1_op_r <= s1_op_r;
        end
    end

    // S2 valid bit takes S1's valid whenever S2 can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
        end else if (s2_free_s) begin
            s2_valid_r <= s1_valid_r;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // S2 result capture when S1 holds a request and S2 can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_cond_r  <= 1'b0;
            s2_flags_r <= 4'b0000;
        end else if (s2_free_s && s1_valid_r) begin
            s2_cond_r  <= cond_s;
            s2_flags_r <= flags_s;
        end else begin
            s2_cond_r  <= s2_cond_r;
            s2_flags_r <= s2_flags_r;
        end
    end

endmodule

// File: tb/tb_set_stage.sv
// tb_set_stage: scoreboard bench for set_stage (N=32). Expected results are
// pushed on input accept and compared on each output transfer.
module tb_set_stage;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic [3:0]    out_flags;

    typedef struct packed {
        logic [N-1:0] res;
        logic [3:0]   flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   n_acc = 0;
    int   n_stall = 0;
    bit   stream_mode = 1'b0;
    bit   bp_done = 1'b0;

    set_stage #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model built from SystemVerilog signed/unsigned relational operators.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        exp_t r;
        logic eq, lt, gt, uns, c;
        uns = (op == 3'b110) || (op == 3'b111);
        eq  = (a == b);
        if (uns) begin
            lt = (a < b);
            gt = (a > b);
        end else begin
            lt = ($signed(a) < $signed(b));
            gt = ($signed(a) > $signed(b));
        end
        case (op)
            3'b000:  c = eq;
            3'b001:  c = !eq;
            3'b010:  c = lt;
            3'b011:  c = !lt;
            3'b100:  c = lt || eq;
            3'b101:  c = gt;
            3'b110:  c = lt;
            default: c = !lt;
        endcase
        r.res   = '0;
        r.res[0] = c;
        r.flags = {1'b0, gt, lt, eq};
`ifndef CMP_UNSIGNED_EN
        if (uns) begin
            r.res   = '0;
            r.flags = 4'b1000;
        end
`endif
        return r;
    endfunction

    // Scoreboard monitor: pop/compare on output transfer, push on input accept.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check_eq("scoreboard_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_result", 64'(out_result), 64'(e.res));
                    check_eq("sb_flags", 64'(out_flags), 64'(e.flags));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_op));
                n_acc++;
            end
            if (stream_mode && in_valid && !in_ready) n_stall++;
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("send_in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single request on an empty pipeline with explicit latency/result checks.
    task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [2:0] op, input logic [N-1:0] er, input logic [3:0] ef);
        send(a, b, op);
        check_eq({tag, "_valid_after_1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_valid_after_2"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_result"}, 64'(out_result), 64'(er));
        check_eq({tag, "_flags"}, 64'(out_flags), 64'(ef));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #2;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base_out, base_acc;
        logic [N-1:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = 3'b000;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_result", 64'(out_result), 64'd0);
        check_eq("rst_out_flags", 64'(out_flags), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requests and boundaries
        directed("eq55", 32'd5, 32'd5, 3'b000, 32'd1, 4'b0001);
        directed("ne55", 32'd5, 32'd5, 3'b001, 32'd0, 4'b0001);
        directed("lt_sbound", 32'h8000_0000, 32'h7FFF_FFFF, 3'b010, 32'd1, 4'b0010);
        directed("gt_sbound", 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 32'd0, 4'b0010);
        directed("le_eq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 32'd1, 4'b0001);
`ifdef CMP_UNSIGNED_EN
        directed("ltu", 32'hFFFF_FFFF, 32'd1, 3'b110, 32'd0, 4'b0100);
        directed("geu", 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 4'b0100);
`else
        directed("ltu_off", 32'hFFFF_FFFF, 32'd1, 3'b110, 32'd0, 4'b1000);
        directed("geu_off", 32'd3, 32'd1, 3'b111, 32'd0, 4'b1000);
`endif
        drain("directed");

        // Backpressure: four back-to-back requests with out_ready low
        base_out = n_out; base_acc = n_acc;
        out_ready = 1'b0;
        fork
            begin
                send(32'd7, 32'd7, 3'b000);
                send(32'd3, 32'd9, 3'b010);
                send(32'hFFFF_FFFF, 32'd2, 3'b011);
                send(32'd1, 32'd1, 3'b001);
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(posedge clk);
        #2;
        check_eq("bp_accepts", 64'(n_acc - base_acc), 64'd2);
        check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        check_eq("bp_hold_result", 64'(out_result), 64'd1);
        check_eq("bp_hold_flags", 64'(out_flags), 64'b0001);
        repeat (2) @(posedge clk);
        #2;
        check_eq("bp_hold_result_later", 64'(out_result), 64'd1);
        check_eq("bp_no_output", 64'(n_out - base_out), 64'd0);
        out_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (bp_done) break;
            @(posedge clk); #2;
        end
        check_eq("bp_sender_done", 64'(bp_done), 64'd1);
        drain("bp");
        check_eq("bp_outputs", 64'(n_out - base_out), 64'd4);

        // Full-throughput random stream
        @(posedge clk); #1;
        base_out = n_out;
        stream_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom();
            if ($urandom_range(0, 3) == 0) ra[N-1] = ~rb[N-1];
            send(ra, rb, 3'($urandom_range(0, 7)));
        end
        stream_mode = 1'b0;
        drain("stream");
        check_eq("stream_no_stall", 64'(n_stall), 64'd0);
        check_eq("stream_outputs", 64'(n_out - base_out), 64'd100);

        // Reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'd4, 32'd4, 3'b000);
        send(32'd2, 32'd8, 3'b010);
        @(posedge clk); #1;
        check_eq("mid_full_in_ready", 64'(in_ready), 64'd0);
        check_eq("mid_full_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_out_result", 64'(out_result), 64'd0);
        check_eq("mid_rst_out_flags", 64'(out_flags), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check_eq("no_stale_after_rst", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        directed("post_rst_gt", 32'd9, 32'd2, 3'b101, 32'd1, 4'b0100);
        drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
